// File: rtl/pmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : pmem_line_responder
// Purpose  : Line-granular physical-memory responder for the cache pmem
//            interface. Serves one 128-bit line read or write at a time.
//            Each access completes after a programmable number of BUSY edges
//            and is followed by a single-cycle pmem_resp pulse.
// Ports    : clk          - single clock; all state changes on the rising edge
//            reset_n      - asynchronous active-low reset
//            pmem_read    - line read request, held until pmem_resp
//            pmem_write   - line write request, held until pmem_resp
//            pmem_address - byte address; only the line index bits are used
//            pmem_wdata   - write line data
//            pmem_rdata   - read line data, valid in the pmem_resp cycle
//            pmem_resp    - one-cycle completion pulse
//            proto_err    - sticky protocol-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module pmem_line_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int         c_lines  = 2 ** IDX_W;
    localparam logic [7:0] c_cnt_init = 8'(LATENCY - 1);

    // Build-time range check on the latency parameter.
    generate
        if ((LATENCY < 1) || (LATENCY > 255)) begin : g_latency_check
            $error("pmem_line_responder: LATENCY must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_op_write;
    logic [IDX_W-1:0]   r_idx;
    logic [127:0]       r_wdata;
    logic [127:0]       r_rdata;
    logic               r_resp;
    logic               r_proto_err;
    logic [127:0]       r_store [c_lines];

    logic [IDX_W-1:0]   w_idx;
    logic               w_unused_addr;

    // Upper address bits alias; the low nibble selects a byte within the line.
    assign w_idx         = pmem_address[4+IDX_W-1:4];
    assign w_unused_addr = ^pmem_address;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_op_write  <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_resp      <= 1'b0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < c_lines; i++) begin
                r_store[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp <= 1'b0;
                    if (pmem_read || pmem_write) begin
                        // Read wins a simultaneous request; the write is lost
                        // and the collision is flagged.
                        r_op_write <= pmem_write && !pmem_read;
                        r_idx      <= w_idx;
                        r_wdata    <= pmem_wdata;
                        r_cnt      <= c_cnt_init;
                        r_state    <= S_BUSY;
                        if (pmem_read && pmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        if (r_op_write) begin
                            r_store[r_idx] <= r_wdata;
                        end else begin
                            r_rdata <= r_store[r_idx];
                        end
                        r_resp  <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp  <= 1'b0;
                    r_state <= S_IDLE;
                    // The requester must still hold its request while the
                    // response is visible.
                    if (!pmem_read && !pmem_write) begin
                        r_proto_err <= 1'b1;
                    end
                end
                default: begin
                    r_resp  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata = r_rdata;
    assign pmem_resp  = r_resp;
    assign proto_err  = r_proto_err;

endmodule
`default_nettype wire
